// File: rtl/n64adv2_rst_pkg.sv
// Shared types and defaults for the N64Adv2 housekeeping reset sequencer.
// The state encoding is visible on state_o for debug.
package n64adv2_rst_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT      = 3'd4
  } state_t;

  localparam int unsigned DEF_NUM_CH       = 4;
  localparam int unsigned DEF_DLY_W        = 8;
  localparam logic [31:0] DEF_CH_DELAY     = {8'd0, 8'd0, 8'd16, 8'd255};
  localparam logic [3:0]  DEF_PERSIST_MASK = 4'b0001;

  // ceil(log2(n)), never less than 1 so index registers always exist
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/n64adv2_sync_bits.sv
// Multi-bit flip-flop synchroniser chain with synchronous clear.
// Each bit is an independent level; no cross-bit coherency is implied.
module n64adv2_sync_bits
  import n64adv2_rst_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (clr) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/n64adv2_rst_sequencer.sv
// Multi-channel reset sequencer: PLL-lock gating, ordered per-channel release
// with qualified delays, dependency cascade, soft reset and lock-loss restart.
module n64adv2_rst_sequencer
  import n64adv2_rst_pkg::*;
#(
  parameter int unsigned              NUM_CH       = DEF_NUM_CH,
  parameter int unsigned              DLY_W        = DEF_DLY_W,
  parameter logic [NUM_CH*DLY_W-1:0]  CH_DELAY     = DEF_CH_DELAY,
  parameter int unsigned              SYNC_STAGES  = 2,
  parameter int unsigned              SOFT_LEN     = 16,
  parameter logic [NUM_CH-1:0]        PERSIST_MASK = DEF_PERSIST_MASK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked_i,
  input  logic [NUM_CH-1:0] rst_req_n_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic              soft_rst_i,
  output logic [NUM_CH-1:0] nrst_o,
  output logic              seq_done_o,
  output logic [2:0]        state_o
);

  localparam int unsigned IDX_W  = clog2_min1(NUM_CH);
  localparam int unsigned SOFT_W = clog2_min1(SOFT_LEN);
  localparam int unsigned SW     = 2 * NUM_CH + 1;

  logic [SW-1:0]     sync_d;
  logic [SW-1:0]     sync_q;
  logic              lock_s;
  logic [NUM_CH-1:0] en_s;
  logic [NUM_CH-1:0] req_s;

  assign sync_d = {pll_locked_i, ch_en_i, rst_req_n_i};

  n64adv2_sync_bits #(
    .WIDTH  (SW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .clr (rst),
    .d   (sync_d),
    .q   (sync_q)
  );

  assign lock_s = sync_q[SW-1];
  assign en_s   = sync_q[2*NUM_CH-1:NUM_CH];
  assign req_s  = sync_q[NUM_CH-1:0];

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DLY_W-1:0]  cnt;
  logic [SOFT_W-1:0] soft_cnt;
  logic [NUM_CH-1:0] nrst;
  logic              seq_done;

  function automatic logic [IDX_W-1:0] lowest_zero(input logic [NUM_CH-1:0] v);
    lowest_zero = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (!v[i-1]) lowest_zero = IDX_W'(i - 1);
    end
  endfunction

  logic [DLY_W-1:0]  cur_dly;
  logic              cur_qual;
  logic              cur_rel;
  logic [NUM_CH-1:0] idx_oh;
  logic              last_idx;
  int unsigned       req_k;
  logic              req_any_low;
  logic [NUM_CH-1:0] cascade_nrst;
  logic [IDX_W-1:0]  cascade_idx;

  always_comb begin
    cur_dly  = '0;
    cur_qual = 1'b0;
    cur_rel  = 1'b0;
    idx_oh   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_dly   = CH_DELAY[i*DLY_W +: DLY_W];
        cur_qual  = req_s[i] & en_s[i];
        cur_rel   = nrst[i];
        idx_oh[i] = 1'b1;
      end
    end
    last_idx = (idx == IDX_W'(NUM_CH - 1));
  end

  // Downstream channels depend on upstream ones, so a request on k drops k and
  // everything above it; released persistent channels above k are spared.
  always_comb begin
    req_k = NUM_CH;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (!req_s[i-1]) req_k = i - 1;
    end
    req_any_low  = (req_k < NUM_CH);
    cascade_nrst = nrst;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (j >= req_k && !(j > req_k && PERSIST_MASK[j] && nrst[j])) begin
        cascade_nrst[j] = 1'b0;
      end
    end
    // Resume at the lowest dropped channel so nothing below k is skipped
    cascade_idx = lowest_zero(cascade_nrst);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      idx      <= '0;
      cnt      <= '0;
      soft_cnt <= '0;
      nrst     <= '0;
      seq_done <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (state != ST_RESET && !lock_s) begin
        nrst  <= '0;
        cnt   <= '0;
        state <= ST_WAIT_LOCK;
      end else begin
        case (state)
          ST_RESET: begin
            state <= ST_WAIT_LOCK;
          end
          ST_WAIT_LOCK: begin
            state <= ST_RELEASE;
            idx   <= lowest_zero(nrst);
            cnt   <= '0;
          end
          default: begin
            if (req_any_low) begin
              nrst  <= cascade_nrst;
              idx   <= cascade_idx;
              cnt   <= '0;
              state <= ST_RELEASE;
            end else if (soft_rst_i && state != ST_SOFT) begin
              nrst     <= nrst & PERSIST_MASK;
              soft_cnt <= '0;
              state    <= ST_SOFT;
            end else begin
              case (state)
                ST_RELEASE: begin
                  if (cur_rel || (cur_qual && cnt == cur_dly)) begin
                    nrst <= nrst | idx_oh;
                    cnt  <= '0;
                    if (last_idx) begin
                      state    <= ST_RUN;
                      seq_done <= 1'b1;
                    end else begin
                      idx <= idx + 1'b1;
                    end
                  end else if (cur_qual) begin
                    cnt <= cnt + 1'b1;
                  end else begin
                    cnt <= '0;
                  end
                end
                ST_RUN: begin
                  seq_done <= 1'b1;
                end
                ST_SOFT: begin
                  if (soft_cnt == SOFT_W'(SOFT_LEN - 1)) begin
                    cnt <= '0;
                    if (&nrst) begin
                      state    <= ST_RUN;
                      seq_done <= 1'b1;
                    end else begin
                      state <= ST_RELEASE;
                      idx   <= lowest_zero(nrst);
                    end
                  end else begin
                    soft_cnt <= soft_cnt + 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign nrst_o     = nrst;
  assign seq_done_o = seq_done;
  assign state_o    = state;

endmodule

// File: tb/tb_n64adv2_rst_sequencer.sv
// Scoreboard bench for n64adv2_rst_sequencer: a rule-level reference model
// queues the expected outputs per clock edge, a monitor compares on negedge.
module tb_n64adv2_rst_sequencer;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned SL = 16;
  localparam logic [N*DW-1:0] DLY = {8'd0, 8'd2, 8'd4};
  localparam logic [N-1:0]    PM  = 3'b001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pll_locked_i = 1'b1;
  logic [N-1:0] rst_req_n_i = '1;
  logic [N-1:0] ch_en_i = '1;
  logic         soft_rst_i = 1'b0;
  logic [N-1:0] nrst_o;
  logic         seq_done_o;
  logic [2:0]   state_o;

  always #5 clk = ~clk;

  n64adv2_rst_sequencer #(
    .NUM_CH       (N),
    .DLY_W        (DW),
    .CH_DELAY     (DLY),
    .SYNC_STAGES  (SS),
    .SOFT_LEN     (SL),
    .PERSIST_MASK (PM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked_i (pll_locked_i),
    .rst_req_n_i  (rst_req_n_i),
    .ch_en_i      (ch_en_i),
    .soft_rst_i   (soft_rst_i),
    .nrst_o       (nrst_o),
    .seq_done_o   (seq_done_o),
    .state_o      (state_o)
  );

  int checks = 0;
  int errors = 0;

  logic [N*DW-1:0] dly_v = DLY;
  logic [N-1:0]    pm_v  = PM;

  // Reference model: mode numbers are the documented state_o values
  int           m_mode = 0;
  logic [N-1:0] m_rel = '0;
  int           m_ptr = 0;
  int           m_streak = 0;
  int           m_soft_left = 0;
  logic [2*N:0] pipe[$];
  logic [N+3:0] expq[$];

  function automatic int dly_of(input int ch);
    return int'(dly_v[ch*DW +: DW]);
  endfunction

  function automatic int first_unreleased(input logic [N-1:0] rel);
    for (int i = 0; i < N; i++) if (!rel[i]) return i;
    return N;
  endfunction

  task automatic step_ptr();
    if (m_ptr == N - 1) m_mode = 3;
    else m_ptr = m_ptr + 1;
  endtask

  always @(posedge clk) begin : ref_model
    logic [2*N:0] s;
    logic         lk;
    logic [N-1:0] en;
    logic [N-1:0] rq;
    int           k;
    if (rst) begin
      m_mode = 0; m_rel = '0; m_ptr = 0; m_streak = 0; m_soft_left = 0;
      pipe.delete();
      for (int i = 0; i < SS; i++) pipe.push_back('0);
    end else begin
      s = pipe.pop_front();
      pipe.push_back({pll_locked_i, ch_en_i, rst_req_n_i});
      lk = s[2*N];
      en = s[2*N-1:N];
      rq = s[N-1:0];
      if (m_mode != 0 && !lk) begin
        m_rel = '0; m_mode = 1; m_streak = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        m_mode = 2; m_ptr = first_unreleased(m_rel); m_streak = 0;
      end else if (rq != '1) begin
        k = first_unreleased(rq);
        for (int j = k; j < N; j++)
          if (!(j > k && pm_v[j] && m_rel[j])) m_rel[j] = 1'b0;
        m_ptr = first_unreleased(m_rel); m_mode = 2; m_streak = 0;
      end else if (soft_rst_i && m_mode != 4) begin
        m_rel = m_rel & pm_v; m_mode = 4; m_soft_left = SL;
      end else if (m_mode == 2) begin
        if (m_rel[m_ptr]) begin
          step_ptr();
        end else if (rq[m_ptr] && en[m_ptr]) begin
          m_streak = m_streak + 1;
          if (m_streak == dly_of(m_ptr) + 1) begin
            m_rel[m_ptr] = 1'b1; m_streak = 0; step_ptr();
          end
        end else begin
          m_streak = 0;
        end
      end else if (m_mode == 4) begin
        m_soft_left = m_soft_left - 1;
        if (m_soft_left == 0) begin
          m_streak = 0;
          if (&m_rel) m_mode = 3;
          else begin m_mode = 2; m_ptr = first_unreleased(m_rel); end
        end
      end
    end
    expq.push_back({m_rel, (m_mode == 3), 3'(m_mode)});
  end

  int cyc = 0;
  always @(negedge clk) begin : monitor
    logic [N+3:0] e;
    cyc = cyc + 1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks = checks + 1;
      if ({nrst_o, seq_done_o, state_o} !== e) begin
        errors = errors + 1;
        $display("FAIL outputs cyc=%0d: nrst/done/state got %b/%b/%0d expected %b/%b/%0d",
                 cyc, nrst_o, seq_done_o, state_o, e[N+3:4], e[3], e[2:0]);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  int rel_off[N] = '{5, 8, 9};
  int e_cyc;
  int rel_cyc[N];
  int done_at_last;
  int lat;
  int r0;
  bit found;
  int lock_hold;
  int req_hold[N];

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Full ordered release from reset
    e_cyc = -1; done_at_last = 0;
    for (int i = 0; i < N; i++) rel_cyc[i] = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (e_cyc < 0 && state_o == 3'd2) e_cyc = c;
      for (int i = 0; i < N; i++) begin
        if (rel_cyc[i] < 0 && nrst_o[i]) begin
          rel_cyc[i] = c;
          if (i == N - 1) done_at_last = int'(seq_done_o);
        end
      end
    end
    chk("release_entered", int'(e_cyc >= 0), 1);
    for (int i = 0; i < N; i++) chk($sformatf("release_offset_ch%0d", i), rel_cyc[i] - e_cyc, rel_off[i]);
    chk("seq_done_with_last", done_at_last, 1);

    // Cascade from channel 1
    @(negedge clk); rst_req_n_i[1] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 3) rst_req_n_i[1] = 1'b1;
      #1;
      if (lat < 0 && nrst_o == 3'b001) lat = c;
    end
    chk("request_to_nrst_latency", lat, SS + 1);

    // Soft reset with persistent channel 0
    @(negedge clk); soft_rst_i = 1'b1;
    @(negedge clk); soft_rst_i = 1'b0;
    repeat (40) @(negedge clk);

    // One-cycle lock loss then full resequence
    pll_locked_i = 1'b0;
    @(negedge clk); pll_locked_i = 1'b1;
    repeat (30) @(negedge clk);

    // Qualifier drop mid-count on channel 0
    pll_locked_i = 1'b0;
    @(negedge clk); pll_locked_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk); #1;
      if (state_o == 3'd2) found = 1'b1;
    end
    chk("wait_release_timeout", int'(found), 1);
    @(negedge clk); ch_en_i[0] = 1'b0;
    @(negedge clk); ch_en_i[0] = 1'b1;
    r0 = -1;
    for (int c = 3; c < 25; c++) begin
      @(negedge clk); #1;
      if (r0 < 0 && nrst_o[0]) r0 = c;
    end
    chk("qualifier_restart_offset", r0, 9);

    // Soft reset coinciding with synced lock loss
    repeat (10) @(negedge clk);
    pll_locked_i = 1'b0;
    @(negedge clk); pll_locked_i = 1'b1;
    @(negedge clk); soft_rst_i = 1'b1;
    @(negedge clk); soft_rst_i = 1'b0;
    #1;
    chk("lockloss_beats_soft_nrst", int'(nrst_o), 0);
    chk("lockloss_beats_soft_state", int'(state_o), 1);

    // Reset mid-sequence
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midseq_rst_nrst", int'(nrst_o), 0);
    chk("midseq_rst_state", int'(state_o), 0);
    chk("midseq_rst_done", int'(seq_done_o), 0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);

    // Randomised traffic
    lock_hold = 0;
    for (int i = 0; i < N; i++) req_hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      if (lock_hold == 0 && $urandom_range(0, 199) == 0) lock_hold = $urandom_range(1, 4);
      pll_locked_i = (lock_hold == 0);
      if (lock_hold > 0) lock_hold = lock_hold - 1;
      for (int i = 0; i < N; i++) begin
        if (req_hold[i] == 0 && $urandom_range(0, 79) == 0) req_hold[i] = $urandom_range(1, 6);
        rst_req_n_i[i] = (req_hold[i] == 0);
        if (req_hold[i] > 0) req_hold[i] = req_hold[i] - 1;
        ch_en_i[i] = ($urandom_range(0, 7) != 0);
      end
      soft_rst_i = ($urandom_range(0, 59) == 0);
    end
    rst = 1'b0; soft_rst_i = 1'b0; pll_locked_i = 1'b1;
    rst_req_n_i = '1; ch_en_i = '1;
    repeat (3) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
